// File: rtl/nzcv_flag_unit.sv
// nzcv_flag_unit: EX-stage producer of N/Z/C/V condition flags.
// New flags are held in a one-deep pending register, then committed to the
// architectural status register. cond_state forwards the pending entry so a
// conditional instruction immediately behind a flag-setter sees its result.
module nzcv_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_s_bit,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] ex_op_a,
    input  logic [WIDTH-1:0] ex_op_b,
    input  logic             ex_shift_carry,
    input  logic             msr_en,
    input  logic [3:0]       msr_data,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       cond_state,
    output logic [3:0]       status_q,
    output logic             pend_valid
);

    localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010,
                           OP_RSB = 4'b0011, OP_ADD = 4'b0100, OP_ADC = 4'b0101,
                           OP_SBC = 4'b0110, OP_RSC = 4'b0111, OP_TST = 4'b1000,
                           OP_TEQ = 4'b1001, OP_CMP = 4'b1010, OP_CMN = 4'b1011,
                           OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110,
                           OP_MVN = 4'b1111;

    logic [3:0]       pend_flags;
    logic [3:0]       cur_flags;
    logic [3:0]       new_flags;
    logic             cap;
    logic             is_arith;
    logic [WIDTH-1:0] x, y, res;
    logic             cin;
    logic [WIDTH:0]   sum;

    // Newest visible flags: pending entry wins over the committed copy.
    assign cur_flags  = pend_valid ? pend_flags : status_q;
    assign cond_state = cur_flags;
    assign cap        = ex_valid & (ex_s_bit | msr_en) & ~stall & ~flush;

    // Adder operand selection; carry-in for ADC/SBC/RSC comes from forwarded C.
    always_comb begin
        is_arith = 1'b1;
        x        = ex_op_a;
        y        = ex_op_b;
        cin      = 1'b0;
        case (ex_opcode)
            OP_ADD, OP_CMN: begin x = ex_op_a; y = ex_op_b;  cin = 1'b0;         end
            OP_ADC:         begin x = ex_op_a; y = ex_op_b;  cin = cur_flags[1]; end
            OP_SUB, OP_CMP: begin x = ex_op_a; y = ~ex_op_b; cin = 1'b1;         end
            OP_SBC:         begin x = ex_op_a; y = ~ex_op_b; cin = cur_flags[1]; end
            OP_RSB:         begin x = ex_op_b; y = ~ex_op_a; cin = 1'b1;         end
            OP_RSC:         begin x = ex_op_b; y = ~ex_op_a; cin = cur_flags[1]; end
            default:        is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    // Result selection and flag formation; logical ops keep V and take C from the shifter.
    always_comb begin
        res       = sum[WIDTH-1:0];
        new_flags = cur_flags;
        if (!is_arith) begin
            case (ex_opcode)
                OP_AND, OP_TST: res = ex_op_a & ex_op_b;
                OP_EOR, OP_TEQ: res = ex_op_a ^ ex_op_b;
                OP_ORR:         res = ex_op_a | ex_op_b;
                OP_MOV:         res = ex_op_b;
                OP_BIC:         res = ex_op_a & ~ex_op_b;
                OP_MVN:         res = ~ex_op_b;
                default:        res = sum[WIDTH-1:0];
            endcase
        end
        if (msr_en) begin
            new_flags = msr_data;
        end else if (is_arith) begin
            new_flags[3] = res[WIDTH-1];
            new_flags[2] = (res == '0);
            new_flags[1] = sum[WIDTH];
            new_flags[0] = (x[WIDTH-1] == y[WIDTH-1]) & (res[WIDTH-1] != x[WIDTH-1]);
        end else begin
            new_flags[3] = res[WIDTH-1];
            new_flags[2] = (res == '0);
            new_flags[1] = ex_shift_carry;
            new_flags[0] = cur_flags[0];
        end
    end

    // Pending capture and commit; flush drops the pending entry without committing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q   <= 4'b0000;
            pend_flags <= 4'b0000;
            pend_valid <= 1'b0;
        end else begin
            if (pend_valid && !flush)
                status_q <= pend_flags;
            if (cap)
                pend_flags <= new_flags;
            pend_valid <= cap;
        end
    end

endmodule

// File: doc/nzcv_flag_unit.md
Name: nzcv_flag_unit

Overview:
- Producer end of the NZCV condition-flag interface; the condition checker is the consumer.
- Sits in EX: computes N/Z/C/V from the executing data-processing op when the S bit is set, or from an MSR write.
- Holds flags in a one-deep pending register, then commits them to the architectural status register.
- Drives cond_state, with the pending value forwarded, so a back-to-back conditional instruction sees the newest flags.

Parameters:
- WIDTH, 32, datapath width of operands.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX slot holds a real instruction
- ex_s_bit  in  1  instruction requests a flag update
- ex_opcode  in  4  ARM DP opcode: 0000 AND, 0001 EOR, 0010 SUB, 0011 RSB, 0100 ADD, 0101 ADC, 0110 SBC, 0111 RSC, 1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN, 1100 ORR, 1101 MOV, 1110 BIC, 1111 MVN
- ex_op_a  in  WIDTH  Rn value
- ex_op_b  in  WIDTH  shifter operand
- ex_shift_carry  in  1  shifter carry-out
- msr_en  in  1  MSR flag write in EX
- msr_data  in  4  {N,Z,C,V} for MSR
- stall  in  1  EX frozen; no capture this cycle
- flush  in  1  kill EX capture and pending entry
- cond_state  out  4  {N,Z,C,V} = [3]N [2]Z [1]C [0]V, to the condition checker
- status_q  out  4  committed architectural flags
- pend_valid  out  1  pending entry present

Behaviour:
- Reset (rst_n=0 at edge): status_q=0000, pend_flags=0000, pend_valid=0. cond_state therefore reads 0000.
- cur_flags = pend_valid ? pend_flags : status_q. Combinational; cond_state = cur_flags.
- Capture condition: cap = ex_valid & (ex_s_bit | msr_en) & ~stall & ~flush.
- On cap, pend_flags <= new_flags and pend_valid <= 1. Otherwise pend_valid <= 0.
- Commit: if pend_valid & ~flush, then status_q <= pend_flags at the same edge. With flush, the pending entry is dropped and status_q holds.
- Latency:
  - cond_state shows new flags 1 cycle after the capture edge (via pend).
  - status_q shows them 2 cycles after.
- Back-to-back captures: the commit of entry k and the capture of entry k+1 happen on the same edge; there are no bubbles.
- Stall: blocks capture only. An existing pending entry still commits and clears.
- MSR priority: msr_en beats ex_s_bit; new_flags = msr_data verbatim.
- Arithmetic (WIDTH+1-bit sum, x + y + cin):
  - ADD/CMN: x=a, y=b, cin=0.
  - ADC: x=a, y=b, cin=cur C.
  - SUB/CMP: x=a, y=~b, cin=1.
  - SBC: x=a, y=~b, cin=cur C.
  - RSB: x=b, y=~a, cin=1.
  - RSC: x=b, y=~a, cin=cur C.
  - C = sum[WIDTH]. For subtraction C is NOT borrow.
  - V = (x[MSB]==y[MSB]) & (res[MSB]!=x[MSB]).
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - C = ex_shift_carry; V = cur V (preserved).
  - Result: AND/TST a&b; EOR/TEQ a^b; ORR a|b; MOV b; BIC a&~b; MVN ~b.
- All ops: N = res[WIDTH-1]; Z = (res==0).
- Forwarding rule: ADC/SBC/RSC and the preserved V use cur_flags, which includes the pending entry. A dependent op right after a flag-setter therefore uses the new flags.
- Ignored inputs: ex_valid=0, or both ex_s_bit=0 and msr_en=0, leaves flags unchanged. A pending entry still commits.
- Reset mid-operation: rst_n=0 clears pend and status regardless of cap, stall or flush.

Test Plan:
- Reset: hold rst_n=0 2 cycles with ex_valid=1, ex_s_bit=1 → cond_state=0000, status_q=0000, pend_valid=0.
- CMP a=5, b=5, S=1 → next cycle cond_state=0110, pend_valid=1; cycle after, status_q=0110, pend_valid=0.
- ADD a=0x7FFFFFFF, b=1, S=1 → cond_state=1001; then ADD a=0xFFFFFFFF, b=1 the following cycle → cond_state=0110 (Z=1, C=1, V=0).
- Forwarding: SUB a=3, b=1 (→0010, C=1), then immediately ADC a=1, b=1 → result 3, cond_state=0000.
- Logical preserve: set V via MSR 0001, then MOV b=0x80000000 with ex_shift_carry=1 → cond_state=1011.
- Flush/stall:
  - CMP 1,2 with flush=1 at the capture edge → flags unchanged.
  - Capture CMP 1,2 (→1000), then assert flush next cycle → status_q unchanged, pend_valid=0.
  - stall=1 with S=1 → no capture.
